// File: rtl/ahb_slave_port_pkg.sv
// ahb_slave_port_pkg: shared AHB-lite encodings and slave FSM states.
package ahb_slave_port_pkg;
  typedef enum logic [1:0] {HTRANS_IDLE = 2'b00, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_t;
  typedef enum logic [1:0] {HRESP_OKAY = 2'b00, HRESP_ERROR = 2'b01} hresp_t;
  typedef enum logic [2:0] {HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, HSIZE_DWORD} hsize_t;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2} slv_state_t;
endpackage

// File: rtl/ahb_slave_port_if.sv
// ahb_slave_port_if: AHB-lite slave-side bus bundle.
interface ahb_slave_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              Hsel;
  logic [1:0]        Htrans;
  logic              Hwrite;
  logic [2:0]        Hsize;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic              Hreadyin;
  logic              Hreadyout;
  logic [1:0]        Hresp;
  logic [DATA_W-1:0] Hrdata;
  modport master (
    output Hsel, Htrans, Hwrite, Hsize, Haddr, Hwdata, Hreadyin,
    input  Hreadyout, Hresp, Hrdata
  );
  modport slave (
    input  Hsel, Htrans, Hwrite, Hsize, Haddr, Hwdata, Hreadyin,
    output Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb_slave_port_mem.sv
// ahb_slave_port_mem: word RAM with byte-enable write, async read and write-first bypass.
module ahb_slave_port_mem #(
  parameter int DEPTH = 256,
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [NB-1:0]     be_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i)
      for (int i = 0; i < NB; i++)
        if (be_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
  always_comb begin
    rdata_o = mem_q[raddr_i];
    for (int i = 0; i < NB; i++)
      rdata_o[i*8 +: 8] = we_i && be_i[i] && waddr_i == raddr_i ? wdata_i[i*8 +: 8] : rdata_o[i*8 +: 8];
  end
endmodule

// File: rtl/ahb_slave_port.sv
// ahb_slave_port: AHB-lite slave with wait states, byte lanes, two-cycle ERROR and internal RAM.
module ahb_slave_port
  import ahb_slave_port_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 0
) (
  input logic             clock,
  input logic             Hresetn,
  ahb_slave_port_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] WIN = (ADDR_W + 1)'(DEPTH * NB);
  slv_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [OFF_W-1:0]  lane_q, lane_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] off_a;
  logic              legal, ready, accept, last, we;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] rdata;
  assign off_a = bus.Haddr - BASE_ADDR;
  assign legal = bus.Haddr >= BASE_ADDR && {1'b0, off_a} < WIN && bus.Hsize <= 3'(OFF_W) &&
                 (bus.Haddr[OFF_W-1:0] & ~({OFF_W{1'b1}} << bus.Hsize)) == '0;
  // New address phases are only taken while this slave is not stalling the bus.
  assign ready = state_q inside {ST_IDLE, ST_LAST, ST_ERR2};
  assign accept = bus.Hsel & bus.Hreadyin & bus.Htrans[1] & ready;
  assign last = state_q == ST_LAST;
  assign we = last & write_q;
  assign be = ~({NB{1'b1}} << (1 << size_q)) << lane_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    lane_d = lane_q;
    size_d = size_q;
    write_d = write_q;
    if (state_q == ST_WAIT) begin
      cnt_d = cnt_q == '0 ? '0 : cnt_q - 4'd1;
      state_d = cnt_q == '0 ? ST_LAST : ST_WAIT;
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (accept) begin
      state_d = !legal ? ST_ERR1 : WAIT_STATES > 0 ? ST_WAIT : ST_LAST;
      cnt_d = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : '0;
      idx_d = off_a[OFF_W +: IDX_W];
      lane_d = off_a[OFF_W-1:0];
      size_d = bus.Hsize;
      write_d = bus.Hwrite;
    end else begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clock or negedge Hresetn)
    if (!Hresetn) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      lane_q <= '0;
      size_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      lane_q <= lane_d;
      size_q <= size_d;
      write_q <= write_d;
    end
  ahb_slave_port_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .clk_i   (clock),
    .we_i    (we),
    .be_i    (be),
    .waddr_i (idx_q),
    .wdata_i (bus.Hwdata),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );
  assign bus.Hreadyout = !(state_q inside {ST_WAIT, ST_ERR1});
  assign bus.Hresp = state_q inside {ST_ERR1, ST_ERR2} ? HRESP_ERROR : HRESP_OKAY;
  assign bus.Hrdata = last && !write_q ? rdata : '0;
endmodule

// File: tb/tb_ahb_slave_port.sv
// tb_ahb_slave_port: two slaves (0 and 3 wait states) on one bus, checked against a transfer-level model.
module tb_ahb_slave_port;
  import ahb_slave_port_pkg::*;
  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] data;
    logic        wr;
    logic [7:0]  idx;
    logic [3:0]  mask;
  } ent_t;
  logic        clk, rst_n, hsel0, hsel3, hwrite, hready_g, chk_en;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata, v;
  int          vecs = 0, errs = 0, nw;
  ent_t        qb [2][8];
  int          qh [2], qn [2];
  logic [31:0] mm [2][256];
  ahb_slave_port_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  ahb_slave_port_if #(.ADDR_W(32), .DATA_W(32)) if3 ();
  assign hready_g = if0.Hreadyout & if3.Hreadyout;
  assign if0.Hsel = hsel0;
  assign if3.Hsel = hsel3;
  assign {if0.Htrans, if0.Hwrite, if0.Hsize, if0.Haddr, if0.Hwdata, if0.Hreadyin} = {htrans, hwrite, hsize, haddr, hwdata, hready_g};
  assign {if3.Htrans, if3.Hwrite, if3.Hsize, if3.Haddr, if3.Hwdata, if3.Hreadyin} = {htrans, hwrite, hsize, haddr, hwdata, hready_g};
  ahb_slave_port #(.WAIT_STATES(0)) dut0 (.clock(clk), .Hresetn(rst_n), .bus(if0));
  ahb_slave_port #(.WAIT_STATES(3)) dut3 (.clock(clk), .Hresetn(rst_n), .bus(if3));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic push(input int d, input ent_t e);
    qb[d][(qh[d] + qn[d]) % 8] = e;
    qn[d]++;
  endtask
  // Model: each accepted transfer becomes a list of expected data-phase cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      qn[0] = 0;
      qn[1] = 0;
    end else
      for (int d = 0; d < 2; d++) begin
        ent_t e;
        logic rdy_exp;
        int nb, off;
        rdy_exp = qn[d] == 0 || qb[d][qh[d]].rdy;
        if (qn[d] > 0) begin
          e = qb[d][qh[d]];
          qh[d] = (qh[d] + 1) % 8;
          qn[d]--;
          if (e.wr)
            for (int b = 0; b < 4; b++)
              if (e.mask[b]) mm[d][e.idx][b*8 +: 8] = hwdata[b*8 +: 8];
        end
        if (rdy_exp && (d == 0 ? hsel0 : hsel3) && htrans[1]) begin
          nb = 1 << hsize;
          off = int'(haddr % 4);
          if (haddr >= 1024 || nb > 4 || haddr % nb != 0) begin
            push(d, '{rdy: 1'b0, resp: 2'b01, default: '0});
            push(d, '{rdy: 1'b1, resp: 2'b01, default: '0});
          end else begin
            for (int w = 0; w < (d == 0 ? 0 : 3); w++) push(d, '{rdy: 1'b0, default: '0});
            e = '0;
            e.rdy = 1'b1;
            e.wr = hwrite;
            e.idx = haddr[9:2];
            for (int b = 0; b < 4; b++) e.mask[b] = b >= off && b < off + nb;
            e.data = hwrite ? 32'h0 : mm[d][haddr[9:2]];
            push(d, e);
          end
        end
      end
  end
  always @(negedge clk)
    if (chk_en)
      for (int d = 0; d < 2; d++) begin
        ent_t e;
        e = '0;
        e.rdy = 1'b1;
        if (rst_n && qn[d] > 0) e = qb[d][qh[d]];
        chk($sformatf("dut%0d Hreadyout", d * 3), 32'(d == 0 ? if0.Hreadyout : if3.Hreadyout), 32'(e.rdy));
        chk($sformatf("dut%0d Hresp", d * 3), 32'(d == 0 ? if0.Hresp : if3.Hresp), 32'(e.resp));
        chk($sformatf("dut%0d Hrdata", d * 3), d == 0 ? if0.Hrdata : if3.Hrdata, e.data);
      end
  task automatic drive(input int d, input logic s, input logic [1:0] tr, input logic w,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    hsel0 = s && d == 0;
    hsel3 = s && d == 1;
    htrans = tr;
    hwrite = w;
    hsize = sz;
    haddr = a;
    hwdata = wd;
  endtask
  task automatic cyc(input int d, input logic s, input logic [1:0] tr, input logic w,
                     input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bit ok;
    drive(d, s, tr, w, sz, a, wd);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      ok = hready_g;
    end
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL hready timeout: got 0, expected 1 within 40 cycles");
    end
    #2;
  endtask
  task automatic wr(input int d, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    cyc(d, 1, HTRANS_NONSEQ, 1, sz, a, '0);
    cyc(d, 0, HTRANS_IDLE, 0, HSIZE_WORD, '0, wd);
  endtask
  task automatic rd(input int d, input logic [31:0] a, output logic [31:0] rv, output int n);
    bit done;
    cyc(d, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, a, '0);
    drive(d, 0, HTRANS_IDLE, 0, HSIZE_WORD, '0, '0);
    n = 0;
    rv = '0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (hready_g) begin
        rv = d == 0 ? if0.Hrdata : if3.Hrdata;
        done = 1;
      end else n++;
    end
    @(posedge clk);
    #2;
  endtask
  initial begin
    chk_en = 0;
    rst_n = 1;
    drive(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, '0, '0);
    #1 rst_n = 0;
    #1;
    chk("reset dut0 Hreadyout", 32'(if0.Hreadyout), 1);
    chk("reset dut0 Hresp", 32'(if0.Hresp), 0);
    chk("reset dut0 Hrdata", if0.Hrdata, 0);
    chk("reset dut3 Hreadyout", 32'(if3.Hreadyout), 1);
    chk("reset dut3 Hresp", 32'(if3.Hresp), 0);
    chk("reset dut3 Hrdata", if3.Hrdata, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    chk_en = 1;
    // zero-wait write then pipelined read of the same word
    cyc(0, 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, '0);
    cyc(0, 1, HTRANS_SEQ, 0, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
    drive(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, '0, '0);
    #1 chk("ws0 write-read Hrdata", if0.Hrdata, 32'hDEADBEEF);
    @(posedge clk);
    #2;
    // three wait states on a single read
    wr(1, HSIZE_WORD, 32'h20, 32'hCAFEF00D);
    rd(1, 32'h20, v, nw);
    chk("ws3 wait cycles", 32'(nw), 3);
    chk("ws3 read data", v, 32'hCAFEF00D);
    // byte and halfword lanes
    wr(0, HSIZE_WORD, 32'h0, 32'h11223344);
    wr(0, HSIZE_BYTE, 32'h2, 32'h00AA0000);
    rd(0, 32'h0, v, nw);
    chk("byte lane read", v, 32'h11AA3344);
    chk("ws0 wait cycles", 32'(nw), 0);
    wr(1, HSIZE_HALF, 32'h22, 32'hBEEF0000);
    rd(1, 32'h20, v, nw);
    chk("half lane read", v, 32'hBEEFF00D);
    // error responses: out of window, misaligned half, oversized transfer
    cyc(0, 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h400, '0);
    drive(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, '0, 32'hFFFFFFFF);
    #1;
    chk("err1 Hreadyout", 32'(if0.Hreadyout), 0);
    chk("err1 Hresp", 32'(if0.Hresp), 1);
    @(posedge clk);
    #1;
    chk("err2 Hreadyout", 32'(if0.Hreadyout), 1);
    chk("err2 Hresp", 32'(if0.Hresp), 1);
    @(posedge clk);
    #2;
    wr(0, HSIZE_HALF, 32'h1, 32'hFFFFFFFF);
    wr(1, HSIZE_DWORD, 32'h20, 32'hFFFFFFFF);
    rd(0, 32'h0, v, nw);
    chk("mem after errors dut0", v, 32'h11AA3344);
    rd(1, 32'h20, v, nw);
    chk("mem after errors dut3", v, 32'hBEEFF00D);
    // pipeline with BUSY, IDLE and an unselected NONSEQ
    wr(0, HSIZE_WORD, 32'h48, 32'h0BADF00D);
    cyc(0, 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h40, '0);
    cyc(0, 1, HTRANS_BUSY, 1, HSIZE_WORD, 32'h44, 32'hA0A0A0A0);
    cyc(0, 1, HTRANS_SEQ, 1, HSIZE_WORD, 32'h44, '0);
    cyc(0, 1, HTRANS_IDLE, 0, HSIZE_WORD, '0, 32'hB0B0B0B0);
    cyc(0, 0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h48, '0);
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, '0, 32'hC0C0C0C0);
    cyc(0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h40, '0);
    cyc(0, 1, HTRANS_SEQ, 0, HSIZE_WORD, 32'h44, '0);
    cyc(0, 1, HTRANS_SEQ, 0, HSIZE_WORD, 32'h48, '0);
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, '0, '0);
    rd(0, 32'h48, v, nw);
    chk("unselected write ignored", v, 32'h0BADF00D);
    rd(0, 32'h44, v, nw);
    chk("seq write after busy", v, 32'hB0B0B0B0);
    // reset in the middle of a waited write
    wr(1, HSIZE_WORD, 32'h30, 32'h55555555);
    cyc(1, 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h30, '0);
    drive(1, 0, HTRANS_IDLE, 0, HSIZE_WORD, '0, 32'h12345678);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid-wait reset Hreadyout", 32'(if3.Hreadyout), 1);
    chk("mid-wait reset Hresp", 32'(if3.Hresp), 0);
    chk("mid-wait reset Hrdata", if3.Hrdata, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    rd(1, 32'h30, v, nw);
    chk("write dropped by reset", v, 32'h55555555);
    rd(0, 32'h10, v, nw);
    chk("memory kept over reset", v, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
